// File: rtl/fetch_align_pkg.sv
// Shared core parameters and icache port bundles.
// Also carries the fetch aligner state encoding.
package tcore_param;

    localparam int BLK_SIZE = 128;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic            valid;
        logic            ready;
        logic [XLEN-1:0] addr;
        logic            uncached;
    } icache_req_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [BLK_SIZE-1:0] blk;
    } icache_res_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        DRAIN
    } fetch_align_state_e;

endpackage

// File: rtl/rvc_extract.sv
// Picks the halfword at an index of a cache line plus its successor.
// Flags compressed encodings and the last halfword of the line.
module rvc_extract #(
    parameter int  BLK_SIZE = 128,
    localparam int NUM_HW   = BLK_SIZE / 16,
    localparam int IDXW     = $clog2(NUM_HW)
) (
    input  logic [BLK_SIZE-1:0] line,
    input  logic [IDXW-1:0]     idx,
    output logic [15:0]         hw,
    output logic [15:0]         hw_next,
    output logic                is_comp,
    output logic                is_last
);

    logic [BLK_SIZE-1:0] shifted;

    always_comb begin
        shifted = line >> {idx, 4'b0000};
        is_last = (idx == IDXW'(NUM_HW - 1));
        hw      = shifted[15:0];
        hw_next = is_last ? 16'h0000 : shifted[31:16];
        is_comp = (hw[1:0] != 2'b11);
    end

endmodule

// File: rtl/fetch_align.sv
// Fetch aligner: line buffer in front of the icache that extracts
// 32-bit and RVC instructions, stitching ones that cross a line.
module fetch_align
    import tcore_param::*;
#(
    parameter int BLK_SIZE = tcore_param::BLK_SIZE,
    parameter int XLEN     = tcore_param::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            fetch_valid_i,
    input  logic            uncached_i,
    input  logic            flush_i,
    output icache_req_t     cache_req_o,
    input  icache_res_t     cache_res_i,
    output logic [31:0]     inst_o,
    output logic            is_comp_o,
    output logic            inst_valid_o
);

    localparam int BOFFSET = $clog2(BLK_SIZE / 8);
    localparam int NUM_HW  = BLK_SIZE / 16;
    localparam int IDXW    = $clog2(NUM_HW);
    localparam int TAGW    = XLEN - BOFFSET;

    fetch_align_state_e state_q, state_d;

    logic [BLK_SIZE-1:0] line_q;
    logic [TAGW-1:0]     line_tag_q;
    logic                line_vld_q;
    logic [15:0]         hold_q;
    logic [XLEN-1:0]     addr_q;
    logic [31:0]         unc_q;
    logic                unc_vld_q;

    logic [TAGW-1:0] pc_tag;
    logic [IDXW-1:0] hw_idx;
    logic [XLEN-1:0] pc_line;
    logic            hit;

    logic [15:0] buf_hw, buf_next, res_hw, res_next;
    logic        buf_comp, buf_last, res_comp, res_last;

    icache_req_t req;
    logic [31:0] inst;
    logic        ivalid;
    logic        lint_unused;

    assign pc_tag  = pc_i[XLEN-1:BOFFSET];
    assign hw_idx  = pc_i[BOFFSET-1:1];
    assign pc_line = {pc_tag, {BOFFSET{1'b0}}};
    assign hit     = fetch_valid_i & line_vld_q & (line_tag_q == pc_tag);

    assign lint_unused = cache_res_i.ready ^ pc_i[0];

    rvc_extract #(.BLK_SIZE(BLK_SIZE)) u_buf (
        .line    (line_q),
        .idx     (hw_idx),
        .hw      (buf_hw),
        .hw_next (buf_next),
        .is_comp (buf_comp),
        .is_last (buf_last)
    );

    // Uncached lines never enter the buffer, so extract from the response.
    rvc_extract #(.BLK_SIZE(BLK_SIZE)) u_res (
        .line    (cache_res_i.blk),
        .idx     (hw_idx),
        .hw      (res_hw),
        .hw_next (res_next),
        .is_comp (res_comp),
        .is_last (res_last)
    );

    always_comb begin
        state_d      = state_q;
        inst         = '0;
        ivalid       = 1'b0;
        req          = '0;
        req.ready    = (state_q != DRAIN);
        req.uncached = uncached_i;
        unique case (state_q)
            IDLE: begin
                if (unc_vld_q) begin
                    if (fetch_valid_i) begin
                        inst   = unc_q;
                        ivalid = 1'b1;
                    end
                end else if (hit) begin
                    if (buf_comp || !buf_last) begin
                        inst   = {buf_comp ? 16'h0000 : buf_next, buf_hw};
                        ivalid = 1'b1;
                    end else begin
                        state_d = FETCH_HI;
                    end
                end else if (fetch_valid_i) begin
                    state_d = FETCH_LO;
                end
            end
            FETCH_LO: begin
                req.valid = 1'b1;
                req.addr  = addr_q;
                if (cache_res_i.valid) begin
                    if (uncached_i && res_last && !res_comp) begin
                        state_d = FETCH_HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FETCH_HI: begin
                req.valid = 1'b1;
                req.addr  = addr_q;
                if (cache_res_i.valid) begin
                    state_d = IDLE;
                    if (fetch_valid_i) begin
                        inst   = {cache_res_i.blk[15:0], hold_q};
                        ivalid = 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush_i) begin
            inst   = '0;
            ivalid = 1'b0;
            if (state_q == FETCH_LO || state_q == FETCH_HI) begin
                state_d = DRAIN;
            end else begin
                state_d = IDLE;
            end
        end
        if (rst_i) begin
            inst   = '0;
            ivalid = 1'b0;
            req    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            line_q     <= '0;
            line_tag_q <= '0;
            line_vld_q <= 1'b0;
            hold_q     <= '0;
            addr_q     <= '0;
            unc_q      <= '0;
            unc_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            unc_vld_q <= 1'b0;
            if (state_q == IDLE && state_d == FETCH_LO) begin
                addr_q <= pc_line;
            end
            if (state_q == IDLE && state_d == FETCH_HI) begin
                hold_q <= buf_hw;
                addr_q <= pc_line + XLEN'(BLK_SIZE / 8);
            end
            if (!flush_i && cache_res_i.valid) begin
                if ((state_q == FETCH_LO || state_q == FETCH_HI) && !uncached_i) begin
                    line_q     <= cache_res_i.blk;
                    line_tag_q <= addr_q[XLEN-1:BOFFSET];
                    line_vld_q <= 1'b1;
                end
                if (state_q == FETCH_LO && uncached_i) begin
                    if (res_last && !res_comp) begin
                        hold_q <= res_hw;
                        addr_q <= addr_q + XLEN'(BLK_SIZE / 8);
                    end else begin
                        unc_q     <= {res_comp ? 16'h0000 : res_next, res_hw};
                        unc_vld_q <= fetch_valid_i;
                    end
                end
            end
            if (flush_i) begin
                line_vld_q <= 1'b0;
            end
        end
    end

    assign cache_req_o  = req;
    assign inst_o       = inst;
    assign inst_valid_o = ivalid;
    assign is_comp_o    = ivalid & (inst[1:0] != 2'b11);

endmodule
